// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - control and status bundle for the note sequencer
interface note_sequencer_if #(
  parameter int NOTE_W = 4,
  parameter int SEL_W  = 1,
  parameter int IDX_W  = 9
);

  // Transport controls (single-cycle pulses) and song selection
  logic              step_en;
  logic              start_edge;
  logic              stop_edge;
  logic              pause_edge;
  logic [SEL_W-1:0]  song_sel;
  logic              loop_en;

  // Playback status toward the tone-select logic
  logic [NOTE_W-1:0] note_out;
  logic              playing;
  logic              paused;
  logic [IDX_W-1:0]  step_idx;
  logic              done;

  // Controller side: issues pulses, observes status
  modport master (
    output step_en, start_edge, stop_edge, pause_edge, song_sel, loop_en,
    input  note_out, playing, paused, step_idx, done
  );

  // Sequencer side: consumes pulses, produces status
  modport slave (
    input  step_en, start_edge, stop_edge, pause_edge, song_sel, loop_en,
    output note_out, playing, paused, step_idx, done
  );

endinterface

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - multi-song note sequencer with start/stop/pause and looping
module note_sequencer #(
  parameter int              NOTE_W    = 4,
  parameter int              SEQ_LEN   = 260,
  parameter int              NUM_SONGS = 2,
  parameter logic [NOTE_W-1:0] REST_CODE = NOTE_W'(4'hF),
  parameter int              SEL_W     = 1,
  parameter int              IDX_W     = 9
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [NUM_SONGS*SEQ_LEN*NOTE_W-1:0] song_data,
  note_sequencer_if.slave                   bus
);

  localparam int TOT_W = NUM_SONGS * SEQ_LEN * NOTE_W;
  localparam int OFF_W = (TOT_W > 1) ? $clog2(TOT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [SEL_W-1:0] song_q;
  logic             done_q;

  // Out-of-range selections fall back to song 0 so the table slice stays legal
  logic [SEL_W-1:0] sel_fix;
  assign sel_fix = (32'(bus.song_sel) < 32'(NUM_SONGS)) ? bus.song_sel : '0;

  // Playback FSM; priority is stop > start > pause > step in every state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      song_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.stop_edge) begin
            idx_q <= '0;
          end else if (bus.start_edge) begin
            state_q <= S_PLAY;
            idx_q   <= '0;
            song_q  <= sel_fix;
          end
        end
        S_PLAY: begin
          if (bus.stop_edge) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
          end else if (bus.start_edge) begin
            idx_q  <= '0;
            song_q <= sel_fix;
          end else if (bus.pause_edge) begin
            state_q <= S_PAUSE;
          end else if (bus.step_en) begin
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (!bus.loop_en) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_PAUSE: begin
          if (bus.stop_edge) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
          end else if (bus.start_edge) begin
            state_q <= S_PLAY;
            idx_q   <= '0;
            song_q  <= sel_fix;
          end else if (bus.pause_edge) begin
            state_q <= S_PLAY;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Bit offset of the current note: note 0 of each song sits at the top of its slice
  logic [OFF_W-1:0] note_off;
  always_comb begin
    note_off = OFF_W'((int'(song_q) * SEQ_LEN + (SEQ_LEN - 1) - int'(idx_q)) * NOTE_W);
  end

  // Note lookup straight from registered state so the note shows in the first PLAY cycle
  always_comb begin
    bus.note_out = REST_CODE;
    if (state_q == S_PLAY) begin
      bus.note_out = song_data[note_off +: NOTE_W];
    end
  end

  assign bus.playing  = (state_q == S_PLAY);
  assign bus.paused   = (state_q == S_PAUSE);
  assign bus.step_idx = idx_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer
module tb_note_sequencer;

  localparam int NOTE_W    = 4;
  localparam int SEQ_LEN   = 4;
  localparam int NUM_SONGS = 2;
  localparam int SEL_W     = 2;
  localparam int IDX_W     = 2;

  logic clk;
  logic n_rst;
  // song0 = {0,2,4,F} in bits [15:0], song1 = {7,9,B,C} in bits [31:16]
  logic [NUM_SONGS*SEQ_LEN*NOTE_W-1:0] song_data;

  note_sequencer_if #(.NOTE_W(NOTE_W), .SEL_W(SEL_W), .IDX_W(IDX_W)) bus ();

  note_sequencer #(
    .NOTE_W(NOTE_W), .SEQ_LEN(SEQ_LEN), .NUM_SONGS(NUM_SONGS),
    .REST_CODE(4'hF), .SEL_W(SEL_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .song_data(song_data),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] note;
    logic       playing;
    logic       paused;
    logic [1:0] idx;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: compare every queued expectation against the DUT on the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.note_out !== e.note || bus.playing !== e.playing || bus.paused !== e.paused ||
          bus.step_idx !== e.idx || bus.done !== e.done) begin
        n_fail++;
        $display("FAIL %s: got note=%h playing=%b paused=%b idx=%0d done=%b, want note=%h playing=%b paused=%b idx=%0d done=%b",
                 e.name, bus.note_out, bus.playing, bus.paused, bus.step_idx, bus.done,
                 e.note, e.playing, e.paused, e.idx, e.done);
      end
    end
  end

  task automatic expect_out(input string name, input logic [3:0] note, input logic pl,
                            input logic pa, input logic [1:0] idx, input logic dn);
    exp_t e;
    e.name = name; e.note = note; e.playing = pl; e.paused = pa; e.idx = idx; e.done = dn;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: pulses are driven for exactly the cycle ending at the next posedge
  task automatic cyc(input logic st, input logic sp, input logic pz, input logic se,
                     input logic [1:0] sel, input logic lp);
    @(negedge clk);
    bus.start_edge = st;
    bus.stop_edge  = sp;
    bus.pause_edge = pz;
    bus.step_en    = se;
    bus.song_sel   = sel;
    bus.loop_en    = lp;
    @(posedge clk);
    #1;
    bus.start_edge = 1'b0;
    bus.stop_edge  = 1'b0;
    bus.pause_edge = 1'b0;
    bus.step_en    = 1'b0;
  endtask

  task automatic start(input logic [1:0] sel, input logic lp); cyc(1, 0, 0, 0, sel, lp); endtask
  task automatic step(input logic lp);  cyc(0, 0, 0, 1, bus.song_sel, lp); endtask
  task automatic pause();               cyc(0, 0, 1, 0, bus.song_sel, bus.loop_en); endtask
  task automatic stop();                cyc(0, 1, 0, 0, bus.song_sel, bus.loop_en); endtask
  task automatic idle();                cyc(0, 0, 0, 0, bus.song_sel, bus.loop_en); endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    song_data      = 32'h79BC_024F;
    n_rst          = 1'b0;
    bus.start_edge = 1'b0;
    bus.stop_edge  = 1'b0;
    bus.pause_edge = 1'b0;
    bus.step_en    = 1'b0;
    bus.song_sel   = '0;
    bus.loop_en    = 1'b0;

    // Reset state
    @(posedge clk); #1;
    expect_out("reset", 4'hF, 0, 0, 0, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // 1: one-shot song 1
    start(2'd1, 0); expect_out("t1_start", 4'h7, 1, 0, 0, 0);
    step(0);        expect_out("t1_s1",    4'h9, 1, 0, 1, 0);
    step(0);        expect_out("t1_s2",    4'hB, 1, 0, 2, 0);
    step(0);        expect_out("t1_s3",    4'hC, 1, 0, 3, 0);
    step(0);        expect_out("t1_done",  4'hF, 0, 0, 0, 1);
    idle();         expect_out("t1_done_clear", 4'hF, 0, 0, 0, 0);

    // 2: looping song 0
    start(2'd0, 1); expect_out("t2_start", 4'h0, 1, 0, 0, 0);
    step(1);        expect_out("t2_s1", 4'h2, 1, 0, 1, 0);
    step(1);        expect_out("t2_s2", 4'h4, 1, 0, 2, 0);
    step(1);        expect_out("t2_s3", 4'hF, 1, 0, 3, 0);
    step(1);        expect_out("t2_wrap", 4'h0, 1, 0, 0, 0);
    step(1);        expect_out("t2_s5", 4'h2, 1, 0, 1, 0);
    step(1);        expect_out("t2_s6", 4'h4, 1, 0, 2, 0);
    stop();         expect_out("t2_stop", 4'hF, 0, 0, 0, 0);

    // 3: pause holds the index and ignores steps
    start(2'd1, 0); expect_out("t3_start", 4'h7, 1, 0, 0, 0);
    step(0);        expect_out("t3_s1", 4'h9, 1, 0, 1, 0);
    step(0);        expect_out("t3_s2", 4'hB, 1, 0, 2, 0);
    pause();        expect_out("t3_pause", 4'hF, 0, 1, 2, 0);
    step(0);        expect_out("t3_ps1", 4'hF, 0, 1, 2, 0);
    step(0);        expect_out("t3_ps2", 4'hF, 0, 1, 2, 0);
    step(0);        expect_out("t3_ps3", 4'hF, 0, 1, 2, 0);
    pause();        expect_out("t3_resume", 4'hB, 1, 0, 2, 0);

    // 4: coincident pulses and idle-state ignores
    cyc(1, 1, 0, 0, 2'd1, 0); expect_out("t4_stop_over_start", 4'hF, 0, 0, 0, 0);
    pause();                  expect_out("t4_idle_pause_ign", 4'hF, 0, 0, 0, 0);
    step(0);                  expect_out("t4_idle_step_ign", 4'hF, 0, 0, 0, 0);
    start(2'd0, 0);           expect_out("t4_start0", 4'h0, 1, 0, 0, 0);
    step(0);                  expect_out("t4_s1", 4'h2, 1, 0, 1, 0);
    cyc(0, 0, 1, 1, 2'd0, 0); expect_out("t4_pause_over_step", 4'hF, 0, 1, 1, 0);
    stop();                   expect_out("t4_stop_from_pause", 4'hF, 0, 0, 0, 0);

    // 5: out-of-range select and restart mid-song
    start(2'd3, 0); expect_out("t5_sel3", 4'h0, 1, 0, 0, 0);
    step(0);        expect_out("t5_s1", 4'h2, 1, 0, 1, 0);
    step(0);        expect_out("t5_s2", 4'h4, 1, 0, 2, 0);
    start(2'd1, 0); expect_out("t5_restart", 4'h7, 1, 0, 0, 0);
    step(0);        expect_out("t5_r1", 4'h9, 1, 0, 1, 0);
    pause();        expect_out("t5_pause", 4'hF, 0, 1, 1, 0);
    start(2'd0, 0); expect_out("t5_start_from_pause", 4'h0, 1, 0, 0, 0);

    // 6: asynchronous reset mid-play at index 3
    step(0);        expect_out("t6_s1", 4'h2, 1, 0, 1, 0);
    step(0);        expect_out("t6_s2", 4'h4, 1, 0, 2, 0);
    step(0);        expect_out("t6_s3", 4'hF, 1, 0, 3, 0);
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    expect_out("t6_async_reset", 4'hF, 0, 0, 0, 0);
    @(negedge clk);
    n_rst = 1'b1;
    idle();         expect_out("t6_idle_after", 4'hF, 0, 0, 0, 0);
    step(0);        expect_out("t6_idle_step", 4'hF, 0, 0, 0, 0);
    start(2'd1, 0); expect_out("t6_start", 4'h7, 1, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
